adc_moving_avg: RTL and testbench
=================================

// Module: adc_moving_avg
// PURPOSE
//  Downstream stage of r2r_adc: samples its 16-bit ADC_OUT word at a fixed rate and produces a
//  boxcar moving average over the last 2**LOG2_DEPTH samples, with a one-cycle valid strobe.
//  Suppresses ramp-ADC conversion jitter before data reaches display/UART logic.
// PARAMETERS
//  WIDTH        16           sample/average width, matches r2r_adc ADC_OUT
//  LOG2_DEPTH   3            window = 2**LOG2_DEPTH samples (range 1..4)
//  CLOCK_FREQ   100_000_000  system clock, Hz
//  SAMPLE_RATE  1000         sample rate, Hz; SAMPLE_DIV = CLOCK_FREQ/SAMPLE_RATE (>=2)
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous, active-low reset
//  enable     in   1      high = run; low = stop and flush window
//  adc_in     in   WIDTH  ADC word from r2r_adc ADC_OUT, assumed stable between samples
//  avg_out    out  WIDTH  windowed average, registered
//  avg_valid  out  1      one-cycle pulse when avg_out updates
//  filling    out  1      high while window not yet full (state FILL)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, tick counter=0, buffer[*]=0, sum=0, wr_ptr=0,
//    fill_cnt=0, avg_out=0, avg_valid=0, filling=0. Outputs leave reset on the next clk edge.
//  - Tick: counter runs 0..SAMPLE_DIV-1 only while enable=1; tick=1 when counter==SAMPLE_DIV-1,
//    then wraps to 0. enable=0 holds counter at 0. First tick SAMPLE_DIV cycles after enable rises.
//  - FSM states: IDLE, FILL, RUN.
//    IDLE: enable=1 -> FILL (next edge). FILL: filling=1.
//    FILL: on tick, take sample; when fill_cnt reaches 2**LOG2_DEPTH -> RUN.
//    RUN: on every tick, take sample. Any state with enable=0 -> IDLE.
//  - Sample on tick edge: buffer[wr_ptr]<=adc_in; sum<=sum+adc_in-buffer[wr_ptr];
//    wr_ptr<=wr_ptr+1 (wraps mod 2**LOG2_DEPTH).
//  - Arithmetic: sum is WIDTH+LOG2_DEPTH bits, unsigned, never overflows.
//    avg_out = sum_next >> LOG2_DEPTH (truncate, no rounding).
//  - Output: avg_out and avg_valid register on the same edge as the sample, so latency from
//    tick cycle to avg_valid is 1 cycle. avg_valid pulses in RUN, and on the tick that
//    completes FILL. No avg_valid during the rest of FILL. avg_out holds between pulses.
//  - enable falling (any state, incl. mid-FILL or a tick cycle): that tick is ignored. Next edge
//    clears buffer, sum, wr_ptr and fill_cnt, sets state=IDLE and filling=0.
//    avg_out keeps its last value. Re-enable needs a full fresh window.
//  - reset_n asserted mid-operation: immediate clear as above, including avg_out.
// CONFIGURATION
//  ADC_AVG_MINMAX_EN defined: adds outputs min_out/max_out [WIDTH-1:0], reset to
//   WIDTH'hFFFF.../0. They track the min/max raw sample since the last enable rise and update
//   with avg_valid timing. Entry to IDLE reloads them to the reset values.
//  Not defined: ports and logic absent; the rest of the behaviour is identical.
// STRUCTURE
//  Package adc_pkg: ADC_WIDTH=16 localparam; typedef enum logic [1:0] {IDLE,FILL,RUN} avg_state_t;
//   function sample_div(clock_freq, sample_rate).
//  Sub-module sample_tick_gen (clk, reset_n, enable, tick; param DIV) holds the tick counter.
//  Window buffer is a register array (max 16 entries), not BRAM.
// TESTING (LOG2_DEPTH=2, CLOCK_FREQ=1000, SAMPLE_RATE=100 -> SAMPLE_DIV=10)
//  1 reset_n=0 at any time -> avg_out=0, avg_valid=0, filling=0 within the same cycle,
//    before any clk edge.
//  2 enable=1, adc_in=16'h0100 constant -> filling=1 for ~40 cycles, first avg_valid
//    1 cycle after 4th tick with avg_out=16'h0100, then a pulse every 10 cycles.
//  3 After test 2, adc_in steps to 16'h0500 -> next four avg_out = 16'h0200,16'h0300,16'h0400,16'h0500.
//  4 adc_in=16'hFFFF constant -> avg_out=16'hFFFF, no wrap. Then alternate 16'h0001/16'h0002
//    -> avg_out=16'h0001 (truncation).
//  5 enable dropped after 2 samples in FILL, re-raised -> no avg_valid until 4 new ticks;
//    first result averages only post-re-enable samples.
//  6 With ADC_AVG_MINMAX_EN: samples 16'h0010,16'h0080,16'h0004,16'h0040 -> min_out=16'h0004,
//    max_out=16'h0080 at first avg_valid.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC moving-average filter.
//   ADC_WIDTH   : native r2r_adc output word width
//   avg_state_t : filter FSM states
//   sample_div  : clock cycles per sample period
package adc_pkg;

  localparam int unsigned ADC_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } avg_state_t;

  function automatic int unsigned sample_div(input int unsigned clock_freq,
                                             input int unsigned sample_rate);
    return clock_freq / sample_rate;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator: counts 0..DIV-1 while enabled and flags the
// last count of each period. Held at zero while disabled.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : run the counter; low clears it
//   tick         : high during the cycle the counter sits at DIV-1 (registered)
module sample_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] r_cnt;

  // tick is registered one count early so it lines up with r_cnt == DIV-1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      tick  <= 1'b0;
    end else if (!enable) begin
      r_cnt <= '0;
      tick  <= 1'b0;
    end else begin
      if (r_cnt == CW'(DIV - 1)) r_cnt <= '0;
      else                       r_cnt <= r_cnt + CW'(1);
      tick <= (r_cnt == CW'(DIV - 2));
    end
  end

endmodule

// File: rtl/adc_moving_avg.sv
// Boxcar moving average over the last 2**LOG2_DEPTH ADC samples, taken at
// SAMPLE_RATE. Emits a one-cycle avg_valid strobe per sample once the window
// is full. Dropping enable flushes the window.
// Optional feature macro: ADC_AVG_MINMAX_EN adds min_out/max_out tracking of
// the raw samples since enable rose.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : run; low stops and flushes the window
//   adc_in       : ADC word, stable between samples
//   avg_out      : windowed average (truncated), held between strobes
//   avg_valid    : one-cycle pulse when avg_out updates
//   filling      : high while the window is still filling
//   min_out/max_out (ADC_AVG_MINMAX_EN only) : sample extremes
module adc_moving_avg
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH       = ADC_WIDTH,
  parameter int unsigned LOG2_DEPTH  = 3,
  parameter int unsigned CLOCK_FREQ  = 100_000_000,
  parameter int unsigned SAMPLE_RATE = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] adc_in,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic             filling
`ifdef ADC_AVG_MINMAX_EN
  ,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out
`endif
);

  localparam int unsigned DEPTH      = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W      = WIDTH + LOG2_DEPTH;
  localparam int unsigned FCNT_W     = LOG2_DEPTH + 1;
  localparam int unsigned SAMPLE_DIV = sample_div(CLOCK_FREQ, SAMPLE_RATE);

  avg_state_t              r_state;
  avg_state_t              w_state_next;
  logic                    w_tick;
  logic                    w_sample;
  logic                    w_fill_done;
  logic                    w_valid;
  logic [WIDTH-1:0]        r_buf [DEPTH];
  logic [SUM_W-1:0]        r_sum;
  logic [SUM_W-1:0]        w_sum_next;
  logic [LOG2_DEPTH-1:0]   r_wr_ptr;
  logic [FCNT_W-1:0]       r_fill_cnt;

  sample_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (w_tick)
  );

  // A tick coinciding with enable low is discarded
  assign w_sample    = enable && w_tick && (r_state != IDLE);
  assign w_fill_done = (r_state == FILL) && (r_fill_cnt == FCNT_W'(DEPTH - 1));
  assign w_valid     = w_sample && ((r_state == RUN) || w_fill_done);
  // Running sum: add the new sample, drop the one it overwrites
  assign w_sum_next  = r_sum + SUM_W'(adc_in) - SUM_W'(r_buf[r_wr_ptr]);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      filling <= 1'b0;
    end else begin
      r_state <= w_state_next;
      filling <= (w_state_next == FILL);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = FILL;
        FILL:    if (w_sample && w_fill_done) w_state_next = RUN;
        RUN:     w_state_next = RUN;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Window buffer, running sum and averaged output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf      <= '{default: '0};
      r_sum      <= '0;
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      avg_out    <= '0;
      avg_valid  <= 1'b0;
    end else begin
      avg_valid <= w_valid;
      if (!enable) begin
        r_buf      <= '{default: '0};
        r_sum      <= '0;
        r_wr_ptr   <= '0;
        r_fill_cnt <= '0;
      end else if (w_sample) begin
        r_buf[r_wr_ptr] <= adc_in;
        r_sum           <= w_sum_next;
        r_wr_ptr        <= r_wr_ptr + LOG2_DEPTH'(1);
        if (r_state == FILL) r_fill_cnt <= r_fill_cnt + FCNT_W'(1);
      end
      if (w_valid) avg_out <= WIDTH'(w_sum_next >> LOG2_DEPTH);
    end
  end

`ifdef ADC_AVG_MINMAX_EN
  logic [WIDTH-1:0] r_min_run;
  logic [WIDTH-1:0] r_max_run;
  logic [WIDTH-1:0] w_min_next;
  logic [WIDTH-1:0] w_max_next;

  assign w_min_next = (adc_in < r_min_run) ? adc_in : r_min_run;
  assign w_max_next = (adc_in > r_max_run) ? adc_in : r_max_run;

  // Running extremes follow every sample; outputs publish them with avg_valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_min_run <= '1;
      r_max_run <= '0;
      min_out   <= '1;
      max_out   <= '0;
    end else if (!enable) begin
      r_min_run <= '1;
      r_max_run <= '0;
      min_out   <= '1;
      max_out   <= '0;
    end else if (w_sample) begin
      r_min_run <= w_min_next;
      r_max_run <= w_max_next;
      if (w_valid) begin
        min_out <= w_min_next;
        max_out <= w_max_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_moving_avg.sv
// Directed bench for adc_moving_avg with a 4-sample window and a 10-cycle
// sample period. Also exercises min/max outputs when ADC_AVG_MINMAX_EN is set.
module tb_adc_moving_avg;

  typedef struct {
    logic [15:0] adc;
    logic [15:0] exp_avg;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] adc_in;
  logic [15:0] avg_out;
  logic        avg_valid;
  logic        filling;
`ifdef ADC_AVG_MINMAX_EN
  logic [15:0] min_out;
  logic [15:0] max_out;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs [14];

  adc_moving_avg #(
    .WIDTH       (16),
    .LOG2_DEPTH  (2),
    .CLOCK_FREQ  (1000),
    .SAMPLE_RATE (100)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .adc_in    (adc_in),
    .avg_out   (avg_out),
    .avg_valid (avg_valid),
    .filling   (filling)
`ifdef ADC_AVG_MINMAX_EN
    ,
    .min_out   (min_out),
    .max_out   (max_out)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts negedges until avg_valid is seen; n=0 if the budget expires
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (avg_valid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int pulses;

    // Steady-state vectors: adc applied after a strobe, average expected at the next
    vecs[0]  = '{16'h0500, 16'h0200};
    vecs[1]  = '{16'h0500, 16'h0300};
    vecs[2]  = '{16'h0500, 16'h0400};
    vecs[3]  = '{16'h0500, 16'h0500};
    vecs[4]  = '{16'hFFFF, 16'h43BF};
    vecs[5]  = '{16'hFFFF, 16'h827F};
    vecs[6]  = '{16'hFFFF, 16'hC13F};
    vecs[7]  = '{16'hFFFF, 16'hFFFF};
    vecs[8]  = '{16'hFFFF, 16'hFFFF};
    vecs[9]  = '{16'h0001, 16'hBFFF};
    vecs[10] = '{16'h0002, 16'h8000};
    vecs[11] = '{16'h0001, 16'h4000};
    vecs[12] = '{16'h0002, 16'h0001};
    vecs[13] = '{16'h0001, 16'h0001};

    // Async reset before any clock edge
    reset_n = 1'b0;
    enable  = 1'b0;
    adc_in  = 16'h0000;
    #1;
    check("reset_avg_out", avg_out, 16'h0000);
    check("reset_avg_valid", avg_valid, 1'b0);
    check("reset_filling", filling, 1'b0);
    #20;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Fill with a constant: first strobe 40 cycles after enable
    enable = 1'b1;
    adc_in = 16'h0100;
    @(negedge clk);
    check("filling_high", filling, 1'b1);
    wait_valid(60, n);
    check("fill_latency", n, 39);
    check("fill_avg", avg_out, 16'h0100);
    check("fill_done_filling", filling, 1'b0);
    @(negedge clk);
    check("valid_one_cycle", avg_valid, 1'b0);
    wait_valid(12, n);
    check("run_period_first", n, 9);
    check("run_avg_const", avg_out, 16'h0100);

    // Step, full-scale and truncation vectors
    for (int k = 0; k < 14; k++) begin
      adc_in = vecs[k].adc;
      wait_valid(12, n);
      check($sformatf("vec%0d_period", k), n, 10);
      check($sformatf("vec%0d_avg", k), avg_out, vecs[k].exp_avg);
    end

    // Drop enable: avg_out holds, filling clears
    enable = 1'b0;
    @(negedge clk);
    check("disable_filling", filling, 1'b0);
    check("disable_valid", avg_valid, 1'b0);
    repeat (3) @(negedge clk);
    check("disable_avg_hold", avg_out, 16'h0001);

    // Two samples, then drop enable on the tick cycle of the third
    adc_in = 16'h0800;
    enable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      if (avg_valid) pulses++;
    end
    check("partial_fill_no_valid", pulses, 0);
    check("partial_fill_filling", filling, 1'b1);
    enable = 1'b0;
    @(negedge clk);
    check("abort_no_valid", avg_valid, 1'b0);
    check("abort_filling", filling, 1'b0);

    // Re-enable needs a fresh 4-sample window
    adc_in = 16'h0040;
    enable = 1'b1;
    wait_valid(60, n);
    check("refill_latency", n, 40);
    check("refill_avg", avg_out, 16'h0040);

`ifdef ADC_AVG_MINMAX_EN
    enable = 1'b0;
    @(negedge clk);
    check("mm_idle_min", min_out, 16'hFFFF);
    check("mm_idle_max", max_out, 16'h0000);
    enable = 1'b1;
    adc_in = 16'h0010;
    repeat (10) @(negedge clk);
    adc_in = 16'h0080;
    repeat (10) @(negedge clk);
    adc_in = 16'h0004;
    repeat (10) @(negedge clk);
    adc_in = 16'h0040;
    wait_valid(12, n);
    check("mm_latency", n, 10);
    check("mm_min", min_out, 16'h0004);
    check("mm_max", max_out, 16'h0080);
    check("mm_avg", avg_out, 16'h0035);
`endif

    // Reset asserted mid-fill clears outputs without a clock edge
    enable = 1'b0;
    @(negedge clk);
    adc_in = 16'h0123;
    enable = 1'b1;
    repeat (15) @(negedge clk);
    check("prereset_filling", filling, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_avg_out", avg_out, 16'h0000);
    check("midreset_avg_valid", avg_valid, 1'b0);
    check("midreset_filling", filling, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
